// File: rtl/m_code_acquire.sv
// Serial-search acquisition of the 11-stage M-code: correlates a local replica against chip_in, slipping one chip per failed dwell.
// Latency: lock/fail/corr_val update on the clock after the chip boundary that closes a dwell; shift_pulse on the first SLIP cycle.
// Backpressure: none; chip_in is consumed every clock and start is ignored outside IDLE and FAIL.
module m_code_acquire #(
  parameter int          CHIP_CLKS = 3052,
  parameter int          CORR_LEN  = 2047,
  parameter int          THRESH    = 1900,
  parameter int          MAX_SLIPS = 2047,
  parameter logic [10:0] SEED      = 11'b01010101010
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            chip_in,
  output logic                            local_code,
  output logic                            chip_strobe,
  output logic                            shift_pulse,
  output logic                            locked,
  output logic                            fail,
  output logic [$clog2(CORR_LEN+1)-1:0]   corr_val,
  output logic [11:0]                     slip_count
);

  localparam int CW = (CHIP_CLKS > 1) ? $clog2(CHIP_CLKS) : 1;
  localparam int AW = $clog2(CORR_LEN + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CHIP_CLKS - 1);
  localparam logic [CW-1:0] CNT_MID   = CW'(CHIP_CLKS / 2);
  localparam logic [AW-1:0] LEN       = AW'(CORR_LEN);
  localparam logic [AW-1:0] THR       = AW'(THRESH);
  localparam logic [11:0]   LAST_SLIP = 12'(MAX_SLIPS - 1);
  localparam logic [11:0]   SLIP_SAT  = 12'hFFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DWELL  = 3'd1,
    SLIP   = 3'd2,
    LOCKED = 3'd3,
    FAIL   = 3'd4
  } state_t;

  state_t state;
  state_t state_n;

  logic [CW-1:0] chip_cnt;
  logic [10:0]   lfsr_q;
  logic [AW-1:0] agree;
  logic [AW-1:0] samp_idx;

  logic start_go;
  logic running;
  logic tracking;
  logic boundary;
  logic sample_pt;
  logic dwell_end;
  logic pass;
  logic feedback;

  // Start is only honoured when the searcher is parked.
  assign start_go  = start && ((state == IDLE) || (state == FAIL));
  // The chip clock runs in every active state, including SLIP so the freeze lasts exactly one chip.
  assign running   = (state == DWELL) || (state == SLIP) || (state == LOCKED);
  // Accumulation, LFSR advance and chip_strobe happen only while correlating.
  assign tracking  = (state == DWELL) || (state == LOCKED);
  assign boundary  = running && (chip_cnt == CNT_LAST);
  assign sample_pt = tracking && (chip_cnt == CNT_MID);
  // The dwell closes on the first boundary after the final sample has been taken.
  assign dwell_end = tracking && boundary && (samp_idx == LEN);
  assign pass      = (agree >= THR);
  assign feedback  = lfsr_q[10] ^ lfsr_q[9] ^ lfsr_q[8] ^ lfsr_q[7] ^ lfsr_q[6] ^ lfsr_q[0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state decision: dwell results steer DWELL/LOCKED, SLIP lasts one chip period.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, FAIL: begin
        if (start) state_n = DWELL;
      end
      DWELL: begin
        if (dwell_end) begin
          if (pass)                          state_n = LOCKED;
          else if (slip_count == LAST_SLIP)  state_n = FAIL;
          else                               state_n = SLIP;
        end
      end
      LOCKED: begin
        if (dwell_end && !pass) state_n = SLIP;
      end
      SLIP: begin
        if (boundary) state_n = DWELL;
      end
      default: state_n = IDLE;
    endcase
  end

  // Chip timing, replica LFSR, agreement accumulation and dwell bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      chip_cnt   <= '0;
      lfsr_q     <= SEED;
      local_code <= 1'b0;
      agree      <= '0;
      samp_idx   <= '0;
      corr_val   <= '0;
      slip_count <= '0;
    end else if (start_go) begin
      chip_cnt   <= '0;
      lfsr_q     <= SEED;
      local_code <= SEED[10];
      agree      <= '0;
      samp_idx   <= '0;
      slip_count <= '0;
    end else if (running) begin
      chip_cnt <= boundary ? '0 : chip_cnt + 1'b1;
      if (sample_pt) begin
        if ((chip_in == lfsr_q[10]) && (agree != LEN)) agree <= agree + 1'b1;
        if (samp_idx != LEN) samp_idx <= samp_idx + 1'b1;
      end
      if (tracking && boundary) begin
        lfsr_q     <= {lfsr_q[9:0], feedback};
        local_code <= lfsr_q[9];
      end
      if (dwell_end) begin
        corr_val <= agree;
        agree    <= '0;
        samp_idx <= '0;
        if (!pass) begin
          if (state == LOCKED)             slip_count <= '0;
          else if (slip_count != SLIP_SAT) slip_count <= slip_count + 1'b1;
        end
      end
    end
  end

  // Registered status flags and one-cycle pulses, all derived from the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      chip_strobe <= 1'b0;
      shift_pulse <= 1'b0;
      locked      <= 1'b0;
      fail        <= 1'b0;
    end else begin
      chip_strobe <= tracking && boundary;
      shift_pulse <= (state_n == SLIP) && (state != SLIP);
      locked      <= (state_n == LOCKED);
      fail        <= (state_n == FAIL);
    end
  end

endmodule

// File: tb/tb_m_code_acquire.sv
// Directed bench for m_code_acquire: a behavioural M-code generator feeds chip_in with selectable chip delay.
// Latency: expected lock/fail/slip timing is hand-derived in clocks from the start edge.
// Backpressure: not applicable; stimulus is free-running.
module tb_m_code_acquire;

  localparam logic [10:0] SEED = 11'b01010101010;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       chip_in;
  logic       local_code;
  logic       chip_strobe;
  logic       shift_pulse;
  logic       locked;
  logic       fail;
  logic [4:0] corr_val;
  logic [11:0] slip_count;

  always #5 clk = ~clk;

  m_code_acquire #(
    .CHIP_CLKS(8),
    .CORR_LEN(16),
    .THRESH(15),
    .MAX_SLIPS(20),
    .SEED(SEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .chip_in(chip_in),
    .local_code(local_code),
    .chip_strobe(chip_strobe),
    .shift_pulse(shift_pulse),
    .locked(locked),
    .fail(fail),
    .corr_val(corr_val),
    .slip_count(slip_count)
  );

  function automatic logic [10:0] lfsr_step(input logic [10:0] q);
    return {q[9:0], q[10] ^ q[9] ^ q[8] ^ q[7] ^ q[6] ^ q[0]};
  endfunction

  // Behavioural transmitter: 8 clk/chip, gen_off chips of initial delay, optional one-chip delay on each DUT slip.
  logic        gen_go = 1'b0;
  logic        quiet  = 1'b0;
  logic        invert = 1'b0;
  logic        follow = 1'b0;
  int          gen_off = 0;
  logic [2:0]  g_cnt = 3'd0;
  logic [10:0] g_q = SEED;
  int          g_hold = 0;

  always @(posedge clk) begin
    if (gen_go) begin
      g_cnt  <= 3'd0;
      g_q    <= SEED;
      g_hold <= gen_off;
    end else begin
      g_cnt <= g_cnt + 3'd1;
      if (g_cnt == 3'd7) begin
        if (g_hold > 0) g_hold <= g_hold - 1;
        else            g_q <= lfsr_step(g_q);
      end
      if (follow && shift_pulse) g_hold <= g_hold + 1;
    end
  end

  assign chip_in = quiet ? 1'b0 : (g_q[10] ^ invert);

  int n_tests = 0;
  int n_fail  = 0;
  int n_shift, n_strobe, bad_strobe, win, max_corr, lock_cycles;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    n_shift = 0; n_strobe = 0; bad_strobe = 0; win = 0; max_corr = 0; lock_cycles = 0;
  endtask

  // One clock; outputs are observed on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (win > 0) begin
      if (chip_strobe) bad_strobe++;
      win--;
    end
    if (shift_pulse) begin
      n_shift++;
      win = 8;
    end
    if (chip_strobe) n_strobe++;
    if (int'(corr_val) > max_corr) max_corr = int'(corr_val);
    if (locked) lock_cycles++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    quiet = 1'b0;
    invert = 1'b0;
    follow = 1'b0;
  endtask

  task automatic do_start(input int off);
    clr_mon();
    gen_off = off;
    start = 1'b1;
    gen_go = 1'b1;
    tick();
    start = 1'b0;
    gen_go = 1'b0;
  endtask

  // which: 0 = locked, 1 = fail, 2 = shift_pulse. lat = -1 if the budget expires.
  task automatic wait_for(input int which, input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if ((which == 0 && locked) || (which == 1 && fail) || (which == 2 && shift_pulse)) begin
        lat = i;
        break;
      end
    end
  endtask

  typedef struct {
    int offset;
    int lat;
    int slips;
    int shifts;
    int strobes;
  } vec_t;

  vec_t        vecs[4];
  int          lat;
  logic [10:0] exp_q;

  initial begin
    // offset: generator delay in chips; lat: clocks from start edge to locked visible;
    // strobes: chips advanced by the replica = 16 per dwell.
    vecs[0] = '{offset: 0, lat: 128, slips: 0, shifts: 0, strobes: 16};
    vecs[1] = '{offset: 1, lat: 264, slips: 1, shifts: 1, strobes: 32};
    vecs[2] = '{offset: 2, lat: 400, slips: 2, shifts: 2, strobes: 48};
    vecs[3] = '{offset: 3, lat: 536, slips: 3, shifts: 3, strobes: 64};
    clr_mon();

    // Reset state.
    do_reset();
    check("rst_local_code", local_code, 0);
    check("rst_chip_strobe", chip_strobe, 0);
    check("rst_shift_pulse", shift_pulse, 0);
    check("rst_locked", locked, 0);
    check("rst_fail", fail, 0);
    check("rst_corr_val", corr_val, 0);
    check("rst_slip_count", slip_count, 0);
    check("rst_lfsr", dut.lfsr_q, SEED);
    check("rst_state_idle", int'(dut.state), 0);
    clr_mon();
    repeat (10) tick();
    check("idle_counter_stopped", dut.chip_cnt, 0);
    check("idle_no_strobe", n_strobe, 0);

    // Acquisition at several generator offsets.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      do_start(vecs[v].offset);
      wait_for(0, 800, lat);
      check($sformatf("lock_latency[off=%0d]", vecs[v].offset), lat, vecs[v].lat);
      check($sformatf("slip_count[off=%0d]", vecs[v].offset), slip_count, vecs[v].slips);
      check($sformatf("corr_val[off=%0d]", vecs[v].offset), corr_val, 16);
      check($sformatf("shift_pulses[off=%0d]", vecs[v].offset), n_shift, vecs[v].shifts);
      check($sformatf("chip_strobes[off=%0d]", vecs[v].offset), n_strobe, vecs[v].strobes);
      check($sformatf("strobe_in_slip[off=%0d]", vecs[v].offset), bad_strobe, 0);
      check($sformatf("fail_flag[off=%0d]", vecs[v].offset), fail, 0);
      exp_q = SEED;
      repeat (vecs[v].strobes) exp_q = lfsr_step(exp_q);
      check($sformatf("local_code[off=%0d]", vecs[v].offset), local_code, exp_q[10]);
      check($sformatf("replica_state[off=%0d]", vecs[v].offset), dut.lfsr_q, exp_q);
    end

    // Lock loss: one fully inverted dwell, then the transmitter follows the slip and lock returns.
    do_reset();
    do_start(0);
    wait_for(0, 200, lat);
    check("ll_initial_lock", lat, 128);
    invert = 1'b1;
    follow = 1'b1;
    clr_mon();
    wait_for(2, 200, lat);
    invert = 1'b0;
    check("ll_slip_latency", lat, 128);
    check("ll_corr_val", corr_val, 0);
    check("ll_locked_low", locked, 0);
    check("ll_slip_count", slip_count, 0);
    wait_for(0, 300, lat);
    follow = 1'b0;
    check("ll_relock_latency", lat, 136);
    check("ll_relock_corr", corr_val, 16);
    check("ll_relock_slips", slip_count, 0);
    check("ll_shift_pulses", n_shift, 1);
    check("ll_strobe_in_slip", bad_strobe, 0);

    // No signal: every dwell fails until the slip budget is exhausted.
    do_reset();
    quiet = 1'b1;
    do_start(0);
    wait_for(1, 3500, lat);
    check("ns_fail_latency", lat, 2712);
    check("ns_fail_flag", fail, 1);
    check("ns_slip_count", slip_count, 20);
    check("ns_shift_pulses", n_shift, 19);
    check("ns_chip_strobes", n_strobe, 320);
    check("ns_never_locked", lock_cycles, 0);
    check("ns_corr_below_thresh", max_corr < 15, 1);
    check("ns_strobe_in_slip", bad_strobe, 0);
    exp_q = SEED;
    repeat (320) exp_q = lfsr_step(exp_q);
    check("ns_lfsr_at_fail", dut.lfsr_q, exp_q);
    clr_mon();
    repeat (40) tick();
    check("ns_frozen_strobes", n_strobe, 0);
    check("ns_frozen_shifts", n_shift, 0);
    check("ns_frozen_lfsr", dut.lfsr_q, exp_q);
    check("ns_frozen_counter", dut.chip_cnt, 0);
    check("ns_fail_held", fail, 1);
    check("ns_slips_held", slip_count, 20);
    do_start(0);
    check("ns_restart_fail", fail, 0);
    check("ns_restart_slips", slip_count, 0);

    // Reset mid-dwell, with a start pulse during DWELL that must be ignored.
    do_reset();
    do_start(0);
    repeat (19) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    check("md_agree_after_5", dut.agree, 5);
    check("md_samples_after_5", dut.samp_idx, 5);
    check("md_counter_phase", dut.chip_cnt, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("md_state_idle", int'(dut.state), 0);
    check("md_lfsr_seed", dut.lfsr_q, SEED);
    check("md_counter", dut.chip_cnt, 0);
    check("md_agree", dut.agree, 0);
    check("md_outputs", {local_code, chip_strobe, shift_pulse, locked, fail, corr_val, slip_count}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
